// File: rtl/d8m_pix_if.sv
// d8m_pix_if: raw Bayer parallel pixel bus (data, LVAL, FVAL, frame status)
interface d8m_pix_if;
  logic [9:0] pix_d;
  logic       pix_hs;
  logic       pix_vs;
  logic       frame_done;
  logic [7:0] frame_cnt;
  modport master(output pix_d, pix_hs, pix_vs, frame_done, frame_cnt);
  modport slave(input pix_d, pix_hs, pix_vs, frame_done, frame_cnt);
endinterface

// File: rtl/d8m_pattern_tx.sv
// d8m_pattern_tx: synthetic D8M Bayer source; LFSR_NOISE_EN makes pattern 3 LFSR noise instead of flat 10'h200
module d8m_pattern_tx #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 480,
  parameter int V_BLANK  = 45,
  parameter int BAR_W    = 80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  d8m_pix_if.master  pix
);
  localparam int H_TOT = H_ACTIVE + H_BLANK;
  localparam int V_TOT = V_ACTIVE + V_BLANK;
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state_q, state_d;
  logic [15:0] x_q, y_q, x_d, y_d;
  logic [1:0]  pat_q, pat_d;
  logic        run, eol, eof, active, last, start, is_g, is_r, comp;
  logic [2:0]  bar;
  logic [9:0]  noise, pat_pix;
  always_comb begin
    run     = state_q == RUN;
    eol     = x_q == 16'(H_TOT - 1);
    eof     = eol && y_q == 16'(V_TOT - 1);
    active  = run && x_q < 16'(H_ACTIVE) && y_q < 16'(V_ACTIVE);
    last    = run && x_q == 16'(H_ACTIVE - 1) && y_q == 16'(V_ACTIVE - 1);
    start   = run ? eof : enable;
    state_d = run ? ((eof && !enable) ? IDLE : RUN) : (enable ? RUN : IDLE);
    x_d     = (run && !eol) ? x_q + 16'd1 : 16'd0;
    y_d     = (!run || eof) ? 16'd0 : eol ? y_q + 16'd1 : y_q;
    pat_d   = start ? pattern_sel : pat_q;
    bar     = 3'(x_q / 16'(BAR_W));
    is_g    = x_q[0] == y_q[0];
    is_r    = !y_q[0] && x_q[0];
    comp    = is_g ? bar[1] : is_r ? bar[2] : bar[0];
    pat_pix = pat_q == 2'd0 ? {10{comp}} :
              pat_q == 2'd1 ? x_q[9:0] :
              pat_q == 2'd2 ? {10{x_q[5] ^ y_q[5]}} : noise;
  end
`ifdef LFSR_NOISE_EN
  logic [9:0] lfsr_q;
  // Reseeded at every frame start so each frame repeats exactly
  always_ff @(posedge clk) begin
    if (reset || start) lfsr_q <= 10'h001;
    else if (active) lfsr_q <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
  end
  assign noise = lfsr_q;
`else
  assign noise = 10'h200;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      x_q            <= '0;
      y_q            <= '0;
      pat_q          <= '0;
      pix.pix_d      <= '0;
      pix.pix_hs     <= 1'b0;
      pix.pix_vs     <= 1'b0;
      pix.frame_done <= 1'b0;
      pix.frame_cnt  <= '0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      pat_q          <= pat_d;
      pix.pix_d      <= active ? pat_pix : 10'h000;
      pix.pix_hs     <= active;
      pix.pix_vs     <= run && y_q < 16'(V_ACTIVE);
      pix.frame_done <= last;
      pix.frame_cnt  <= pix.frame_cnt + {7'd0, last};
    end
  end
endmodule
